k423_if_predec: RTL and testbench
=================================

K423_IF_PREDEC -- requirements
Module: k423_if_predec

Interface
REQ-001 The block SHALL have parameter FETCH_W, default 2, meaning 32-bit instruction slots per fetch packet (legal 1..8).
REQ-002 The block SHALL have parameter IDX_W, default (FETCH_W>1 ? $clog2(FETCH_W) : 1), meaning the slot index width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the core clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port flush_i, input, 1 bit: discards the held packet and the incoming packet.
REQ-007 The block SHALL have port in_vld_i, input, 1 bit: fetch packet valid.
REQ-008 The block SHALL have port in_rdy_o, output, 1 bit: the stage can accept a packet.
REQ-009 The block SHALL have port in_pc_i, input, `CORE_XLEN bits: PC of slot 0.
REQ-010 The block SHALL have port in_inst_i, input, FETCH_W*32 bits: slot i is bits [32i+31:32i].
REQ-011 The block SHALL have port in_mask_i, input, FETCH_W bits: per-slot instruction valid.
REQ-012 The block SHALL have port out_vld_o, output, 1 bit: the decoded packet is valid.
REQ-013 The block SHALL have port out_rdy_i, input, 1 bit: the downstream stage accepts the packet.
REQ-014 The block SHALL have port out_pc_o, output, `CORE_XLEN bits: registered in_pc_i.
REQ-015 The block SHALL have ports out_br_o, out_bxx_o, out_jal_o, out_jalr_o, out_call_o and out_ret_o, outputs, FETCH_W bits each: per-slot decode flags.
REQ-016 The block SHALL have port out_imm_o, output, FETCH_W*`CORE_XLEN bits: per-slot immediate.
REQ-017 The block SHALL have port out_first_vld_o, output, 1 bit: at least one masked slot is a branch.
REQ-018 The block SHALL have port out_first_idx_o, output, IDX_W bits: lowest masked slot index whose br flag is set.
REQ-019 The block SHALL have port out_first_dir_o, output, 1 bit: the first branch is BXX or JAL, so its target is computable.
REQ-020 The block SHALL have port out_first_tgt_o, output, `CORE_XLEN bits: target of the first branch.

Function
REQ-021 Per-slot decode SHALL be combinational on the input side and SHALL be gated by the in_mask_i bit: a masked-off slot decodes to all flags 0 and imm 0.
REQ-022 For a slot to decode as any branch type, its opcode[1:0] SHALL be 2'b11.
REQ-023 A slot SHALL decode as BXX when opcode[6:2]=11000, as JAL when 11011, and as JALR when 11001.
REQ-024 br SHALL equal bxx|jal|jalr.
REQ-025 call SHALL be set when the slot is (jal|jalr) and rd is x1 or x5.
REQ-026 ret SHALL be set when the slot is jalr, rs1 is x1 or x5, and rd != rs1.
REQ-027 The immediate SHALL be the J-type immediate when inst[3]=1 and the B-type immediate otherwise; both are sign-extended to XLEN with bit 0 = 0.
REQ-028 Slot i PC SHALL equal in_pc_i + 4*i, mod 2^XLEN (wrap-around permitted).
REQ-029 The first-branch selection SHALL use a priority encoder that picks the lowest index i with mask[i] & br[i].
REQ-030 out_first_tgt_o SHALL equal pc_i + imm_i when dir=1, and SHALL be 0 otherwise.
REQ-031 out_first_idx_o, out_first_dir_o and out_first_tgt_o SHALL be 0 when out_first_vld_o=0.
REQ-032 The block SHALL be a single registered pipeline stage: all out_* signals come from flops, with latency 1 cycle from accept to out_vld_o.
REQ-033 in_rdy_o SHALL equal (!out_vld_o | out_rdy_i), is combinational and SHALL be independent of in_vld_i.
REQ-034 A packet SHALL be accepted when in_vld_i & in_rdy_o & !flush_i, and all registers SHALL load on acceptance.
REQ-035 A held packet (out_vld_o & !out_rdy_i) SHALL keep every output stable.
REQ-036 When accept and out_rdy_i occur in the same cycle, the next packet SHALL replace the current one with no bubble, giving a throughput of 1 packet per cycle.
REQ-037 When out_rdy_i is set and there is no accept, out_vld_o SHALL go to 0 on the next edge.
REQ-038 flush_i SHALL take priority over all other events: on the next edge out_vld_o=0 and the incoming packet is dropped, even if in_vld_i=1 and out_rdy_i=0.
REQ-039 While out_vld_o=0, the payload registers SHALL hold their last value; downstream SHALL qualify the payload with out_vld_o.

Reset
REQ-040 While rst_n_i=0, out_vld_o SHALL be 0, and all payload outputs (pc, flags, imm, first_*) SHALL be 0.
REQ-041 Reset SHALL be asserted asynchronously and deasserted synchronously to clk_i by the external reset synchroniser.
REQ-042 Reset asserted mid-transfer SHALL discard the held packet immediately.
REQ-043 in_rdy_o SHALL be 1 in the first cycle after reset release.

Verification
REQ-044 Scenario (JAL call): FETCH_W=2, pc=0x1000, slot0=0x00000013 (nop), slot1=0x008000EF (jal x1,+8), mask=11 -> the next cycle shows out_vld=1, jal=10, call=10, first_vld=1, idx=1, dir=1, tgt=0x100C.
REQ-045 Scenario (JALR return): slot0=0x00008067 (jalr x0,0(x1)), mask=01 -> jalr=01, ret=01, call=00, first_idx=0, dir=0, tgt=0.
REQ-046 Scenario (backward BXX with masked slot): pc=0x0, slot0=0xFE000EE3 (beq -4), slot1=jal, mask=10 -> slot0 flags all 0, first_idx=1; with mask=11 -> first_idx=0, imm0=0xFFFFFFFC, tgt=0xFFFFFFFC (wrap).
REQ-047 Scenario (backpressure): hold out_rdy_i=0 for 3 cycles with in_vld_i=1 -> in_rdy_o=0 and outputs stable; raise out_rdy_i -> the new packet appears the next cycle with no loss or duplication.
REQ-048 Scenario (flush during stall): out_vld=1, out_rdy=0, flush_i=1, in_vld=1 -> out_vld=0 the next cycle and the incoming packet never appears.
REQ-049 Scenario (async reset mid-transfer): assert rst_n_i=0 between clock edges while out_vld=1 -> out_vld=0 and all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/k423_if_predec.sv
// Fetch-packet predecoder: flags per-slot branches, extracts immediates and picks the first
// branch of each packet, presented through a single registered valid/ready stage.
`timescale 1ns/1ps

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module k423_if_predec #(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned IDX_W   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,

  input  logic                          in_vld_i,
  output logic                          in_rdy_o,
  input  logic [`CORE_XLEN-1:0]         in_pc_i,
  input  logic [FETCH_W*32-1:0]         in_inst_i,
  input  logic [FETCH_W-1:0]            in_mask_i,

  output logic                          out_vld_o,
  input  logic                          out_rdy_i,
  output logic [`CORE_XLEN-1:0]         out_pc_o,
  output logic [FETCH_W-1:0]            out_br_o,
  output logic [FETCH_W-1:0]            out_bxx_o,
  output logic [FETCH_W-1:0]            out_jal_o,
  output logic [FETCH_W-1:0]            out_jalr_o,
  output logic [FETCH_W-1:0]            out_call_o,
  output logic [FETCH_W-1:0]            out_ret_o,
  output logic [FETCH_W*`CORE_XLEN-1:0] out_imm_o,
  output logic                          out_first_vld_o,
  output logic [IDX_W-1:0]              out_first_idx_o,
  output logic                          out_first_dir_o,
  output logic [`CORE_XLEN-1:0]         out_first_tgt_o
);

  localparam int unsigned XLEN = `CORE_XLEN;

  // Combinational decode of the incoming packet
  logic [FETCH_W-1:0]      dec_br, dec_bxx, dec_jal, dec_jalr, dec_call, dec_ret;
  logic [FETCH_W*XLEN-1:0] dec_imm;
  logic [31:0]             slot;
  logic                    slot_std, slot_bxx, slot_jal, slot_jalr;
  logic [4:0]              slot_rd, slot_rs1;
  logic                    rd_link, rs1_link;
  logic [XLEN-1:0]         j_imm, b_imm;

  always_comb begin
    dec_br    = '0;
    dec_bxx   = '0;
    dec_jal   = '0;
    dec_jalr  = '0;
    dec_call  = '0;
    dec_ret   = '0;
    dec_imm   = '0;
    slot      = '0;
    slot_std  = 1'b0;
    slot_bxx  = 1'b0;
    slot_jal  = 1'b0;
    slot_jalr = 1'b0;
    slot_rd   = '0;
    slot_rs1  = '0;
    rd_link   = 1'b0;
    rs1_link  = 1'b0;
    j_imm     = '0;
    b_imm     = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      slot      = in_inst_i[32*i +: 32];
      slot_std  = (slot[1:0] == 2'b11);
      slot_bxx  = slot_std && (slot[6:2] == 5'b11000);
      slot_jal  = slot_std && (slot[6:2] == 5'b11011);
      slot_jalr = slot_std && (slot[6:2] == 5'b11001);
      slot_rd   = slot[11:7];
      slot_rs1  = slot[19:15];
      rd_link   = (slot_rd == 5'd1) || (slot_rd == 5'd5);
      rs1_link  = (slot_rs1 == 5'd1) || (slot_rs1 == 5'd5);
      j_imm     = {{(XLEN-20){slot[31]}}, slot[19:12], slot[20], slot[30:21], 1'b0};
      b_imm     = {{(XLEN-12){slot[31]}}, slot[7], slot[30:25], slot[11:8], 1'b0};
      if (in_mask_i[i]) begin
        dec_bxx[i]  = slot_bxx;
        dec_jal[i]  = slot_jal;
        dec_jalr[i] = slot_jalr;
        dec_br[i]   = slot_bxx | slot_jal | slot_jalr;
        dec_call[i] = (slot_jal | slot_jalr) & rd_link;
        dec_ret[i]  = slot_jalr & rs1_link & (slot_rd != slot_rs1);
        // inst[3] separates JAL (1101111) from B-type (1100011)
        dec_imm[XLEN*i +: XLEN] = slot[3] ? j_imm : b_imm;
      end
    end
  end

  // First-branch priority encoder; scanning downward lets the lowest index win
  logic            first_vld, first_dir;
  logic [IDX_W-1:0] first_idx;
  logic [XLEN-1:0]  first_tgt;
  logic [XLEN-1:0]  slot_pc;

  always_comb begin
    first_vld = 1'b0;
    first_dir = 1'b0;
    first_idx = '0;
    first_tgt = '0;
    slot_pc   = '0;
    for (int i = int'(FETCH_W) - 1; i >= 0; i--) begin
      if (dec_br[i]) begin
        slot_pc   = in_pc_i + XLEN'(4 * i);
        first_vld = 1'b1;
        first_idx = IDX_W'(i);
        first_dir = dec_bxx[i] | dec_jal[i];
        first_tgt = first_dir ? slot_pc + dec_imm[XLEN*i +: XLEN] : '0;
      end
    end
  end

  // Pipeline register control
  logic vld_q, vld_d;
  logic accept;

  assign in_rdy_o = ~vld_q | out_rdy_i;
  assign accept   = in_vld_i & in_rdy_o & ~flush_i;

  always_comb begin
    vld_d = vld_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d = 1'b1;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  logic [XLEN-1:0]         pc_q;
  logic [FETCH_W-1:0]      br_q, bxx_q, jal_q, jalr_q, call_q, ret_q;
  logic [FETCH_W*XLEN-1:0] imm_q;
  logic                    first_vld_q, first_dir_q;
  logic [IDX_W-1:0]        first_idx_q;
  logic [XLEN-1:0]         first_tgt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q       <= 1'b0;
      pc_q        <= '0;
      br_q        <= '0;
      bxx_q       <= '0;
      jal_q       <= '0;
      jalr_q      <= '0;
      call_q      <= '0;
      ret_q       <= '0;
      imm_q       <= '0;
      first_vld_q <= 1'b0;
      first_dir_q <= 1'b0;
      first_idx_q <= '0;
      first_tgt_q <= '0;
    end else begin
      vld_q <= vld_d;
      // Payload only moves on accept so it holds while stalled or idle
      if (accept) begin
        pc_q        <= in_pc_i;
        br_q        <= dec_br;
        bxx_q       <= dec_bxx;
        jal_q       <= dec_jal;
        jalr_q      <= dec_jalr;
        call_q      <= dec_call;
        ret_q       <= dec_ret;
        imm_q       <= dec_imm;
        first_vld_q <= first_vld;
        first_dir_q <= first_dir;
        first_idx_q <= first_idx;
        first_tgt_q <= first_tgt;
      end
    end
  end

  assign out_vld_o       = vld_q;
  assign out_pc_o        = pc_q;
  assign out_br_o        = br_q;
  assign out_bxx_o       = bxx_q;
  assign out_jal_o       = jal_q;
  assign out_jalr_o      = jalr_q;
  assign out_call_o      = call_q;
  assign out_ret_o       = ret_q;
  assign out_imm_o       = imm_q;
  assign out_first_vld_o = first_vld_q;
  assign out_first_idx_o = first_idx_q;
  assign out_first_dir_o = first_dir_q;
  assign out_first_tgt_o = first_tgt_q;

endmodule

// File: tb/tb_k423_if_predec.sv
// Bench for k423_if_predec: directed scenarios plus random traffic checked against a
// packet-level reference model of the decode rules and valid/ready stage.
`timescale 1ns/1ps

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

module tb_k423_if_predec;

  localparam int unsigned FW = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned XL = 32;

  typedef struct packed {
    logic [XL-1:0]    pc;
    logic [FW-1:0]    br;
    logic [FW-1:0]    bxx;
    logic [FW-1:0]    jal;
    logic [FW-1:0]    jalr;
    logic [FW-1:0]    call;
    logic [FW-1:0]    ret;
    logic [FW*XL-1:0] imm;
    logic             fvld;
    logic [IW-1:0]    fidx;
    logic             fdir;
    logic [XL-1:0]    ftgt;
  } pkt_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_vld, in_rdy;
  logic [XL-1:0]    in_pc;
  logic [FW*32-1:0] in_inst;
  logic [FW-1:0]    in_mask;
  logic             out_vld, out_rdy;
  logic [XL-1:0]    out_pc;
  logic [FW-1:0]    out_br, out_bxx, out_jal, out_jalr, out_call, out_ret;
  logic [FW*XL-1:0] out_imm;
  logic             out_first_vld, out_first_dir;
  logic [IW-1:0]    out_first_idx;
  logic [XL-1:0]    out_first_tgt;

  always #5 clk = ~clk;

  k423_if_predec #(
    .FETCH_W (FW)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .flush_i         (flush),
    .in_vld_i        (in_vld),
    .in_rdy_o        (in_rdy),
    .in_pc_i         (in_pc),
    .in_inst_i       (in_inst),
    .in_mask_i       (in_mask),
    .out_vld_o       (out_vld),
    .out_rdy_i       (out_rdy),
    .out_pc_o        (out_pc),
    .out_br_o        (out_br),
    .out_bxx_o       (out_bxx),
    .out_jal_o       (out_jal),
    .out_jalr_o      (out_jalr),
    .out_call_o      (out_call),
    .out_ret_o       (out_ret),
    .out_imm_o       (out_imm),
    .out_first_vld_o (out_first_vld),
    .out_first_idx_o (out_first_idx),
    .out_first_dir_o (out_first_dir),
    .out_first_tgt_o (out_first_tgt)
  );

  int unsigned n_chk;
  int unsigned n_fail;
  logic        m_vld;
  pkt_t        m_pkt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode of a whole packet, straight from the instruction-set encodings
  function automatic pkt_t predict(input logic [XL-1:0] pc, input logic [FW*32-1:0] ins,
                                   input logic [FW-1:0] m);
    pkt_t       p;
    logic [31:0] w;
    int         imm;
    logic       isb, isj, isr;
    logic [4:0] rd, rs1;
    p    = '0;
    p.pc = pc;
    for (int i = 0; i < int'(FW); i++) begin
      w = ins[32*i +: 32];
      if (m[i]) begin
        isb = (w[6:0] == 7'h63);
        isj = (w[6:0] == 7'h6f);
        isr = (w[6:0] == 7'h67);
        rd  = w[11:7];
        rs1 = w[19:15];
        if (w[3])
          imm = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
              + (int'(w[30:21]) << 1);
        else
          imm = (w[31] ? -(1 << 12) : 0) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5)
              + (int'(w[11:8]) << 1);
        p.bxx[i]  = isb;
        p.jal[i]  = isj;
        p.jalr[i] = isr;
        p.br[i]   = isb | isj | isr;
        p.call[i] = (isj | isr) && (rd == 5'd1 || rd == 5'd5);
        p.ret[i]  = isr && (rs1 == 5'd1 || rs1 == 5'd5) && (rd != rs1);
        p.imm[32*i +: 32] = 32'(imm);
        if (!p.fvld && p.br[i]) begin
          p.fvld = 1'b1;
          p.fidx = IW'(i);
          p.fdir = isb | isj;
          p.ftgt = p.fdir ? pc + 32'(4 * i) + 32'(imm) : '0;
        end
      end
    end
    return p;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, ".vld"},  64'(out_vld),       64'(m_vld));
    check({pfx, ".pc"},   64'(out_pc),        64'(m_pkt.pc));
    check({pfx, ".br"},   64'(out_br),        64'(m_pkt.br));
    check({pfx, ".bxx"},  64'(out_bxx),       64'(m_pkt.bxx));
    check({pfx, ".jal"},  64'(out_jal),       64'(m_pkt.jal));
    check({pfx, ".jalr"}, 64'(out_jalr),      64'(m_pkt.jalr));
    check({pfx, ".call"}, 64'(out_call),      64'(m_pkt.call));
    check({pfx, ".ret"},  64'(out_ret),       64'(m_pkt.ret));
    check({pfx, ".imm"},  out_imm,            m_pkt.imm);
    check({pfx, ".fvld"}, 64'(out_first_vld), 64'(m_pkt.fvld));
    check({pfx, ".fidx"}, 64'(out_first_idx), 64'(m_pkt.fidx));
    check({pfx, ".fdir"}, 64'(out_first_dir), 64'(m_pkt.fdir));
    check({pfx, ".ftgt"}, 64'(out_first_tgt), 64'(m_pkt.ftgt));
  endtask

  // Called at a falling edge: drive, check ready, advance the model, check the result
  task automatic cycle(input logic v, input logic [XL-1:0] p, input logic [FW*32-1:0] ins,
                       input logic [FW-1:0] m, input logic ordy, input logic fl);
    logic exp_rdy, acc;
    in_vld  = v;
    in_pc   = p;
    in_inst = ins;
    in_mask = m;
    out_rdy = ordy;
    flush   = fl;
    #1;
    exp_rdy = !m_vld || ordy;
    check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    acc = v && exp_rdy && !fl;
    if (fl) begin
      m_vld = 1'b0;
    end else if (acc) begin
      m_vld = 1'b1;
      m_pkt = predict(p, ins, m);
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
    check_outputs("out");
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_vld = 1'b0;
    m_pkt = '0;
    check_outputs("rst");
    check("rst.in_rdy", 64'(in_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h63;
      1: w[6:0] = 7'h6f;
      2: w[6:0] = 7'h67;
      3: w[6:0] = 7'h13;
      4: w[6:0] = {5'b11001, 2'($urandom_range(0, 2))};
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) w[11:7] = pick_reg();
    if ($urandom_range(0, 1) == 1) w[19:15] = pick_reg();
    return w;
  endfunction

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] JAL8 = 32'h008000EF;
  localparam logic [31:0] RET  = 32'h00008067;
  localparam logic [31:0] BEQM = 32'hFE000EE3;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    m_vld   = 1'b0;
    m_pkt   = '0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    in_vld  = 1'b0;
    in_pc   = '0;
    in_inst = '0;
    in_mask = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset.in_rdy", 64'(in_rdy), 64'd1);
    rst_n = 1'b1;
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);

    // JAL call in slot 1
    cycle(1'b1, 32'h1000, {JAL8, NOP}, 2'b11, 1'b1, 1'b0);
    check("s1.vld", 64'(out_vld), 64'd1);
    check("s1.jal", 64'(out_jal), 64'b10);
    check("s1.call", 64'(out_call), 64'b10);
    check("s1.fvld", 64'(out_first_vld), 64'd1);
    check("s1.fidx", 64'(out_first_idx), 64'd1);
    check("s1.fdir", 64'(out_first_dir), 64'd1);
    check("s1.ftgt", 64'(out_first_tgt), 64'h100C);

    // JALR return in slot 0
    cycle(1'b1, 32'h2000, {NOP, RET}, 2'b01, 1'b1, 1'b0);
    check("s2.jalr", 64'(out_jalr), 64'b01);
    check("s2.ret", 64'(out_ret), 64'b01);
    check("s2.call", 64'(out_call), 64'b00);
    check("s2.fidx", 64'(out_first_idx), 64'd0);
    check("s2.fdir", 64'(out_first_dir), 64'd0);
    check("s2.ftgt", 64'(out_first_tgt), 64'd0);

    // Backward branch, first masked then unmasked
    cycle(1'b1, 32'h0, {JAL8, BEQM}, 2'b10, 1'b1, 1'b0);
    check("s3.bxx", 64'(out_bxx), 64'b00);
    check("s3.imm0", 64'(out_imm[31:0]), 64'd0);
    check("s3.fidx", 64'(out_first_idx), 64'd1);
    cycle(1'b1, 32'h0, {JAL8, BEQM}, 2'b11, 1'b1, 1'b0);
    check("s3b.fidx", 64'(out_first_idx), 64'd0);
    check("s3b.imm0", 64'(out_imm[31:0]), 64'hFFFFFFFC);
    check("s3b.ftgt", 64'(out_first_tgt), 64'hFFFFFFFC);

    // Backpressure: packet B must wait, then appear exactly once
    cycle(1'b1, 32'hA000, {NOP, JAL8}, 2'b11, 1'b1, 1'b0);
    repeat (3) begin
      cycle(1'b1, 32'hB000, {BEQM, NOP}, 2'b11, 1'b0, 1'b0);
      check("s4.hold_pc", 64'(out_pc), 64'hA000);
    end
    cycle(1'b1, 32'hB000, {BEQM, NOP}, 2'b11, 1'b1, 1'b0);
    check("s4.new_pc", 64'(out_pc), 64'hB000);
    check("s4.new_vld", 64'(out_vld), 64'd1);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("s4.drain_vld", 64'(out_vld), 64'd0);

    // Flush while stalled drops both held and incoming packets
    cycle(1'b1, 32'hC000, {JAL8, RET}, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 32'hD000, {RET, JAL8}, 2'b11, 1'b0, 1'b1);
    check("s5.vld", 64'(out_vld), 64'd0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("s5.pc_kept", 64'(out_pc), 64'hC000);

    // Asynchronous reset with a packet held
    cycle(1'b1, 32'hE000, {JAL8, BEQM}, 2'b11, 1'b0, 1'b0);
    async_reset();
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 32'($urandom), {rand_inst(), rand_inst()},
              2'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
